// File: rtl/txrx_seq.sv
// Packet sequencer: runs one TX or RX packet per command by driving the txrx
// register block over a single-outstanding valid/ready bus.
module txrx_seq #(
   parameter int TXRX_ADDR_W    = 4,
   parameter int A_TX_DATA      = 0,
   parameter int A_TX_START     = 1,
   parameter int A_TX_EN        = 2,
   parameter int A_TX_READY     = 3,
   parameter int A_AA           = 4,
   parameter int A_CH_IDX       = 5,
   parameter int A_RX_START     = 6,
   parameter int A_RX_EN        = 7,
   parameter int A_DEMOD_EN     = 8,
   parameter int A_RX_DATA      = 9,
   parameter int A_RX_EMPTY     = 10,
   parameter int A_RX_AA_FOUND  = 11,
   parameter int A_RX_CRC_VALID = 12,
   parameter int TIMEOUT_W      = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   input  logic                   cmd_rx,
   input  logic [7:0]             cmd_len,
   input  logic [5:0]             cmd_ch_idx,
   input  logic [31:0]            cmd_aa,
   input  logic [TIMEOUT_W-1:0]   cmd_timeout,
   input  logic [7:0]             txb_data,
   input  logic                   txb_valid,
   output logic                   txb_ready,
   output logic [7:0]             rxb_data,
   output logic                   rxb_valid,
   input  logic                   rxb_ready,
   output logic                   m_valid,
   output logic [TXRX_ADDR_W-1:0] m_address,
   output logic [31:0]            m_wdata,
   output logic                   m_wstrb,
   input  logic [31:0]            m_rdata,
   input  logic                   m_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   crc_ok,
   output logic                   timeout,
   output logic [4:0]             dbg_state
);

   // Handshakes: cmd is taken when cmd_valid is high in IDLE; txb/rxb bytes move
   // on a rising edge with valid&ready both high; a bus access completes on the
   // edge where m_valid&m_ready, and request fields are frozen until then.
   typedef enum logic [4:0] {
      IDLE, CFG_CH, CFG_AA, TX_EN, TX_FETCH, TX_WR, TX_GO, TX_POLL, TX_STOP,
      TX_DIS, RX_EN, RX_DEMOD, RX_ARM, RX_CLR, RX_WAIT_AA, RX_EMPTY, RX_READ,
      RX_PUSH, RX_CRC, DISABLE, DONE
   } state_t;

   state_t                 state, state_d;
   logic                   rx_q;
   logic [7:0]             len_q;
   logic [5:0]             ch_q;
   logic [31:0]            aa_q;
   logic [TIMEOUT_W-1:0]   tmo_q;
   logic [TIMEOUT_W-1:0]   tmo_cnt;
   logic [7:0]             cnt;
   logic [7:0]             tx_byte;
   logic                   dis_step;
   logic                   ack_pend;
   logic                   acc_req;
   logic                   acc_wr;
   logic [TXRX_ADDR_W-1:0] acc_addr;
   logic [31:0]            acc_data;
   logic                   acc_done;
   logic                   issue;
   logic                   last_byte;
   logic                   set_timeout;
   logic                   unused_rdata;

   function automatic logic [TXRX_ADDR_W-1:0] ra(input int a);
      return TXRX_ADDR_W'(a);
   endfunction

   assign acc_done     = m_valid & m_ready;
   // A new request waits until the responder has dropped m_ready after the last one.
   assign issue        = acc_req & ~m_valid & ~(ack_pend & m_ready);
   assign last_byte    = ((cnt + 8'd1) == len_q);
   assign unused_rdata = ^m_rdata[31:8];

   assign txb_ready = (state == TX_FETCH);
   assign rxb_valid = (state == RX_PUSH);
   assign busy      = (state != IDLE) && (state != DONE);
   assign done      = (state == DONE);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d     = state;
      acc_req     = 1'b0;
      acc_wr      = 1'b0;
      acc_addr    = '0;
      acc_data    = '0;
      set_timeout = 1'b0;
      case (state)
         IDLE: if (cmd_valid) state_d = CFG_CH;
         CFG_CH: begin
            acc_req = 1'b1; acc_wr = 1'b1; acc_addr = ra(A_CH_IDX); acc_data = {26'd0, ch_q};
            if (acc_done) state_d = CFG_AA;
         end
         CFG_AA: begin
            acc_req = 1'b1; acc_wr = 1'b1; acc_addr = ra(A_AA); acc_data = aa_q;
            if (acc_done) state_d = rx_q ? RX_EN : TX_EN;
         end
         TX_EN: begin
            acc_req = 1'b1; acc_wr = 1'b1; acc_addr = ra(A_TX_EN); acc_data = 32'd1;
            if (acc_done) state_d = (len_q == 8'd0) ? TX_GO : TX_FETCH;
         end
         TX_FETCH: if (txb_valid) state_d = TX_WR;
         TX_WR: begin
            acc_req = 1'b1; acc_wr = 1'b1; acc_addr = ra(A_TX_DATA); acc_data = {24'd0, tx_byte};
            if (acc_done) state_d = last_byte ? TX_GO : TX_FETCH;
         end
         TX_GO: begin
            acc_req = 1'b1; acc_wr = 1'b1; acc_addr = ra(A_TX_START); acc_data = 32'd1;
            if (acc_done) state_d = TX_POLL;
         end
         TX_POLL: begin
            acc_req = 1'b1; acc_addr = ra(A_TX_READY);
            if (acc_done && m_rdata[0]) state_d = TX_STOP;
         end
         TX_STOP: begin
            acc_req = 1'b1; acc_wr = 1'b1; acc_addr = ra(A_TX_START);
            if (acc_done) state_d = TX_DIS;
         end
         TX_DIS: begin
            acc_req = 1'b1; acc_wr = 1'b1; acc_addr = ra(A_TX_EN);
            if (acc_done) state_d = DISABLE;
         end
         RX_EN: begin
            acc_req = 1'b1; acc_wr = 1'b1; acc_addr = ra(A_RX_EN); acc_data = 32'd1;
            if (acc_done) state_d = RX_DEMOD;
         end
         RX_DEMOD: begin
            acc_req = 1'b1; acc_wr = 1'b1; acc_addr = ra(A_DEMOD_EN); acc_data = 32'd1;
            if (acc_done) state_d = RX_ARM;
         end
         RX_ARM: begin
            acc_req = 1'b1; acc_wr = 1'b1; acc_addr = ra(A_RX_START); acc_data = 32'd1;
            if (acc_done) state_d = RX_CLR;
         end
         RX_CLR: begin
            acc_req = 1'b1; acc_wr = 1'b1; acc_addr = ra(A_RX_START);
            if (acc_done) state_d = RX_WAIT_AA;
         end
         RX_WAIT_AA: begin
            // Once the counter expires no new poll starts; an in-flight one is finished first.
            acc_req  = ~timeout;
            acc_addr = ra(A_RX_AA_FOUND);
            if (acc_done) begin
               if (m_rdata[0] && !timeout) begin
                  state_d = (len_q == 8'd0) ? RX_CRC : RX_EMPTY;
               end else if (timeout || (tmo_cnt == '0)) begin
                  set_timeout = 1'b1;
                  state_d     = DISABLE;
               end
            end else if (timeout && !m_valid) begin
               state_d = DISABLE;
            end
            if ((tmo_cnt == TIMEOUT_W'(1)) && !(acc_done && m_rdata[0])) set_timeout = 1'b1;
         end
         RX_EMPTY: begin
            acc_req = 1'b1; acc_addr = ra(A_RX_EMPTY);
            if (acc_done && !m_rdata[0]) state_d = RX_READ;
         end
         RX_READ: begin
            acc_req = 1'b1; acc_addr = ra(A_RX_DATA);
            if (acc_done) state_d = RX_PUSH;
         end
         RX_PUSH: if (rxb_ready) state_d = last_byte ? RX_CRC : RX_EMPTY;
         RX_CRC: begin
            acc_req = 1'b1; acc_addr = ra(A_RX_CRC_VALID);
            if (acc_done) state_d = DISABLE;
         end
         DISABLE: begin
            if (rx_q) begin
               acc_req  = 1'b1; acc_wr = 1'b1;
               acc_addr = dis_step ? ra(A_DEMOD_EN) : ra(A_RX_EN);
               if (acc_done && dis_step) state_d = DONE;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid   <= 1'b0;
         m_address <= '0;
         m_wdata   <= '0;
         m_wstrb   <= 1'b0;
         ack_pend  <= 1'b0;
         rx_q      <= 1'b0;
         len_q     <= '0;
         ch_q      <= '0;
         aa_q      <= '0;
         tmo_q     <= '0;
         tmo_cnt   <= '0;
         cnt       <= '0;
         tx_byte   <= '0;
         rxb_data  <= '0;
         dis_step  <= 1'b0;
         crc_ok    <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         if (issue) begin
            m_valid   <= 1'b1;
            m_address <= acc_addr;
            m_wdata   <= acc_wr ? acc_data : 32'd0;
            m_wstrb   <= acc_wr;
         end else if (acc_done) begin
            m_valid   <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            m_wstrb   <= 1'b0;
         end
         if (acc_done)      ack_pend <= 1'b1;
         else if (!m_ready) ack_pend <= 1'b0;

         if (state == IDLE && cmd_valid) begin
            rx_q     <= cmd_rx;
            len_q    <= cmd_len;
            ch_q     <= cmd_ch_idx;
            aa_q     <= cmd_aa;
            tmo_q    <= cmd_timeout;
            cnt      <= '0;
            dis_step <= 1'b0;
            crc_ok   <= 1'b0;
            timeout  <= 1'b0;
         end
         if (state == RX_CLR && acc_done) tmo_cnt <= tmo_q;
         if (state == RX_WAIT_AA && tmo_cnt != '0) tmo_cnt <= tmo_cnt - TIMEOUT_W'(1);
         if (set_timeout) timeout <= 1'b1;
         if (state == TX_FETCH && txb_valid) tx_byte <= txb_data;
         if ((state == TX_WR && acc_done) || (state == RX_PUSH && rxb_ready)) cnt <= cnt + 8'd1;
         if (state == RX_READ && acc_done) rxb_data <= m_rdata[7:0];
         if (state == RX_CRC && acc_done) crc_ok <= m_rdata[0];
         if (state == DISABLE && acc_done) dis_step <= 1'b1;
      end
   end

endmodule
